// File: rtl/fpga_rst_sequencer.sv
// fpga_rst_sequencer: reset/boot sequencer for the FPGA top.
// Releases clock lock -> DRAM reset/calibration -> SoC/USB reset in order,
// latches the boot mode at SoC release and recovers from lock loss,
// calibration loss or a debounced user reset request.
//
// Ports:
//   clk_i              SoC clock
//   rst_ni             asynchronous active-low reset
//   pll_locked_i       clock wizard lock (async, 2-flop synchronized)
//   dram_calib_done_i  MIG calibration done (async, 2-flop synchronized)
//   usr_rst_req_i      button/VIO reset request (async, synced + debounced)
//   boot_mode_i        boot mode, sampled on the last SOC_RST cycle
//   dram_rst_o         active-high DRAM wrapper reset
//   soc_rst_no         active-low SoC reset
//   usb_rst_no         active-low USB reset (always equals soc_rst_no)
//   boot_mode_o        latched boot mode
//   fail_o             calibration timeout indicator
//   state_o            current state encoding
module fpga_rst_sequencer #(
    parameter int unsigned HoldCycles     = 16,
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned CalibTimeout   = 2**20,
    parameter bit          UseDram        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       dram_calib_done_i,
    input  logic       usr_rst_req_i,
    input  logic [1:0] boot_mode_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic       usb_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       fail_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        DRAM_RST   = 3'd1,
        WAIT_CALIB = 3'd2,
        SOC_RST    = 3'd3,
        RUN        = 3'd4,
        FAIL       = 3'd5
    } state_e;

    localparam int unsigned HW = $clog2(HoldCycles + 1);
    localparam int unsigned TW = $clog2(CalibTimeout + 1);
    localparam int unsigned DW = $clog2(DebounceCycles + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HoldCycles - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(CalibTimeout - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DebounceCycles - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [1:0] lock_sync_q;
    logic [1:0] calib_sync_q;
    logic [1:0] usr_sync_q;
    logic       lock_s;
    logic       calib_s;
    logic       usr_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync_q  <= '0;
            calib_sync_q <= '0;
            usr_sync_q   <= '0;
        end else begin
            lock_sync_q  <= {lock_sync_q[0], pll_locked_i};
            calib_sync_q <= {calib_sync_q[0], dram_calib_done_i};
            usr_sync_q   <= {usr_sync_q[0], usr_rst_req_i};
        end
    end

    assign lock_s  = lock_sync_q[1];
    assign calib_s = calib_sync_q[1];
    assign usr_s   = usr_sync_q[1];

    // ------------------------------------------------------------------
    // User request debounce
    // ------------------------------------------------------------------
    logic          db_stable_q;
    logic          db_stable_d;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          usr_acc;

    // usr_acc pulses on the edge where the stable level goes 0 -> 1, so a
    // held button produces exactly one request.
    always_comb begin
        db_stable_d = db_stable_q;
        db_cnt_d    = '0;
        usr_acc     = 1'b0;
        if (usr_s != db_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_stable_d = usr_s;
                usr_acc     = usr_s;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_stable_q <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            db_stable_q <= db_stable_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic [TW-1:0] tmo_q;
    logic [1:0]    boot_mode_q;
    logic          dram_rst_q;
    logic          soc_rst_n_q;
    logic          fail_q;
    logic [2:0]    state_out_q;
    logic          in_soc;

    assign in_soc = (state_q == RUN) || (state_q == SOC_RST);

    // Outputs are a registered decode of state_q, so every output (and
    // state_o) moves on the same edge, one cycle after the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WAIT_LOCK;
            hold_q      <= '0;
            tmo_q       <= '0;
            boot_mode_q <= 2'b00;
            dram_rst_q  <= UseDram;
            soc_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
            state_out_q <= 3'd0;
        end else begin
            dram_rst_q  <= UseDram &&
                           (state_q == WAIT_LOCK || state_q == DRAM_RST);
            soc_rst_n_q <= (state_q == RUN);
            fail_q      <= (state_q == FAIL);
            state_out_q <= state_q;

            if (state_q != WAIT_LOCK && !lock_s) begin
                state_q <= WAIT_LOCK;
                hold_q  <= '0;
                tmo_q   <= '0;
            end else if (UseDram && in_soc && !calib_s) begin
                state_q <= DRAM_RST;
                hold_q  <= '0;
            end else if (usr_acc && in_soc) begin
                // soft reset: restart the SoC hold, DRAM left alone
                state_q <= SOC_RST;
                hold_q  <= '0;
            end else if (usr_acc && state_q == FAIL) begin
                state_q <= DRAM_RST;
                hold_q  <= '0;
            end else begin
                unique case (state_q)
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state_q <= UseDram ? DRAM_RST : SOC_RST;
                            hold_q  <= '0;
                        end
                    end
                    DRAM_RST: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= WAIT_CALIB;
                            hold_q  <= '0;
                            tmo_q   <= '0;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    WAIT_CALIB: begin
                        if (calib_s) begin
                            state_q <= SOC_RST;
                            hold_q  <= '0;
                            tmo_q   <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= FAIL;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    SOC_RST: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q     <= RUN;
                            hold_q      <= '0;
                            boot_mode_q <= boot_mode_i;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    RUN, FAIL: begin
                    end
                    default: begin
                        state_q <= WAIT_LOCK;
                        hold_q  <= '0;
                        tmo_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign dram_rst_o  = dram_rst_q;
    assign soc_rst_no  = soc_rst_n_q;
    assign usb_rst_no  = soc_rst_n_q;
    assign boot_mode_o = boot_mode_q;
    assign fail_o      = fail_q;
    assign state_o     = state_out_q;

endmodule

// File: tb/tb_fpga_rst_sequencer.sv
// tb_fpga_rst_sequencer: directed + random bench for fpga_rst_sequencer.
// Two instances (with and without DRAM) share stimulus and a reference model.
module tb_fpga_rst_sequencer;

    localparam int HOLD = 4;
    localparam int DEB  = 8;
    localparam int CTMO = 64;

    localparam int P_LOCK = 0;
    localparam int P_DRST = 1;
    localparam int P_WCAL = 2;
    localparam int P_SOCR = 3;
    localparam int P_RUN  = 4;
    localparam int P_FAIL = 5;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       calib;
    logic       usr;
    logic [1:0] bmode;

    logic       dram_rst, soc_rst_n, usb_rst_n, fail;
    logic [1:0] boot;
    logic [2:0] st;
    logic       dram_rst0, soc_rst_n0, usb_rst_n0, fail0;
    logic [1:0] boot0;
    logic [2:0] st0;

    logic [8:0] o1;
    logic [8:0] o0;
    assign o1 = {dram_rst, soc_rst_n, usb_rst_n, boot, fail, st};
    assign o0 = {dram_rst0, soc_rst_n0, usb_rst_n0, boot0, fail0, st0};

    fpga_rst_sequencer #(
        .HoldCycles(HOLD), .DebounceCycles(DEB),
        .CalibTimeout(CTMO), .UseDram(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pll_locked_i(lock), .dram_calib_done_i(calib),
        .usr_rst_req_i(usr), .boot_mode_i(bmode),
        .dram_rst_o(dram_rst), .soc_rst_no(soc_rst_n),
        .usb_rst_no(usb_rst_n), .boot_mode_o(boot),
        .fail_o(fail), .state_o(st)
    );

    fpga_rst_sequencer #(
        .HoldCycles(HOLD), .DebounceCycles(DEB),
        .CalibTimeout(CTMO), .UseDram(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .pll_locked_i(lock), .dram_calib_done_i(calib),
        .usr_rst_req_i(usr), .boot_mode_i(bmode),
        .dram_rst_o(dram_rst0), .soc_rst_no(soc_rst_n0),
        .usb_rst_no(usb_rst_n0), .boot_mode_o(boot0),
        .fail_o(fail0), .state_o(st0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;
    int dram0_hi;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs seen by the sequencer are the pin values from two edges back;
    // the debouncer counts how long that level has disagreed with the
    // accepted level; each sequencer phase counts down its remaining time.
    bit         lk_p1, lk_p2, ca_p1, ca_p2, us_p1, us_p2;
    bit         db_lvl;
    int         db_run;
    int         ph[2];
    int         rem[2];
    int         waited[2];
    bit         m_dram[2];
    bit         m_soc[2];
    bit         m_fail[2];
    logic [1:0] m_boot[2];
    logic [2:0] m_state[2];

    task automatic model_reset();
        lk_p1 = 0; lk_p2 = 0; ca_p1 = 0; ca_p2 = 0; us_p1 = 0; us_p2 = 0;
        db_lvl = 0; db_run = 0;
        for (int m = 0; m < 2; m++) begin
            ph[m] = P_LOCK; rem[m] = 0; waited[m] = 0;
            m_dram[m] = (m == 0); m_soc[m] = 0; m_fail[m] = 0;
            m_boot[m] = 2'b00; m_state[m] = 3'd0;
        end
    endtask

    task automatic enter(input int m, input int p);
        ph[m] = p;
        rem[m] = HOLD;
        waited[m] = 0;
    endtask

    task automatic fsm_step(input int m, input bit lk, input bit ca,
                            input bit acc);
        bit dr;
        bit soc_side;
        dr = (m == 0);
        soc_side = (ph[m] == P_RUN) || (ph[m] == P_SOCR);
        m_dram[m]  = dr && (ph[m] == P_LOCK || ph[m] == P_DRST);
        m_soc[m]   = (ph[m] == P_RUN);
        m_fail[m]  = (ph[m] == P_FAIL);
        m_state[m] = 3'(ph[m]);
        if (ph[m] != P_LOCK && !lk) enter(m, P_LOCK);
        else if (soc_side && dr && !ca) enter(m, P_DRST);
        else if (acc && soc_side) enter(m, P_SOCR);
        else if (acc && ph[m] == P_FAIL) enter(m, P_DRST);
        else begin
            case (ph[m])
                P_LOCK: if (lk) enter(m, dr ? P_DRST : P_SOCR);
                P_DRST: begin
                    rem[m]--;
                    if (rem[m] == 0) enter(m, P_WCAL);
                end
                P_WCAL: begin
                    if (ca) enter(m, P_SOCR);
                    else begin
                        waited[m]++;
                        if (waited[m] == CTMO) enter(m, P_FAIL);
                    end
                end
                P_SOCR: begin
                    rem[m]--;
                    if (rem[m] == 0) begin
                        m_boot[m] = bmode;
                        enter(m, P_RUN);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_step();
        bit lk, ca, us, acc;
        lk = lk_p2; ca = ca_p2; us = us_p2;
        lk_p2 = lk_p1; lk_p1 = lock;
        ca_p2 = ca_p1; ca_p1 = calib;
        us_p2 = us_p1; us_p1 = usr;
        acc = 0;
        if (us != db_lvl) begin
            db_run++;
            if (db_run == DEB) begin
                db_lvl = us;
                db_run = 0;
                acc = us;
            end
        end else begin
            db_run = 0;
        end
        for (int m = 0; m < 2; m++) fsm_step(m, lk, ca, acc);
    endtask

    function automatic logic [8:0] exp_out(input int m);
        return {m_dram[m], m_soc[m], m_soc[m], m_boot[m], m_fail[m],
                m_state[m]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        if (dram_rst0) dram0_hi++;
        chk("out_dram", o1, exp_out(0));
        chk("out_nodram", o0, exp_out(1));
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              input string tag);
        for (int i = 0; i < budget && st !== s; i++) cyc();
        chk(tag, st, s);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_vals", o1, 9'b1_0_0_00_0_000);
        chk("arst_vals0", o0, 9'b0_0_0_00_0_000);
        cyc();
        rst_n = 1'b1;
    endtask

    int         first0, cnt, cnt1, cnt2, n3, ent, dhi, k, len;
    int         t_x, t_soc;
    logic       dram_wc, seen_wc;
    logic [2:0] prev;
    logic [1:0] nb;

    initial begin
        n_vec = 0; n_err = 0; dram0_hi = 0;
        rst_n = 1'b1; lock = 0; calib = 0; usr = 0; bmode = 2'b00;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_vals", o1, 9'b1_0_0_00_0_000);
        chk("rst_vals0", o0, 9'b0_0_0_00_0_000);
        repeat (2) cyc();
        rst_n = 1'b1;

        // nominal boot
        repeat (5) cyc();
        lock = 1; bmode = 2'b10;
        first0 = -1; cnt1 = 0; dram_wc = 1'b1; seen_wc = 1'b0;
        t_x = -100; t_soc = -200;
        for (int i = 0; i < 40; i++) begin
            if (i == 15) calib = 1;
            cyc();
            if (first0 < 0 && st0 != 3'd0) first0 = int'(st0);
            if (st == 3'd1 && dram_rst) cnt1++;
            if (st == 3'd2 && !seen_wc) begin
                seen_wc = 1'b1;
                dram_wc = dram_rst;
            end
            if (st == 3'd3 && t_x < 0) t_x = i;
            if (soc_rst_n && t_soc < 0) t_soc = i;
        end
        chk("nom_drst_len", cnt1, HOLD);
        chk("nom_dram_wc", dram_wc, 0);
        chk("nom_soc_lat", t_soc - t_x, HOLD);
        chk("nom_boot", boot, 2'b10);
        chk("nodram_path", first0, 3);

        // calibration timeout, then user exit from FAIL
        calib = 0;
        cnt2 = 0;
        for (int i = 0; i < 200 && st != 3'd5; i++) begin
            cyc();
            if (st == 3'd2) cnt2++;
        end
        chk("tmo_len", cnt2, CTMO);
        chk("tmo_state", st, 5);
        chk("tmo_fail", fail, 1);
        len = $urandom_range(12, 30);
        usr = 1;
        for (int i = 0; i < 60 && st != 3'd1; i++) begin
            if (i == len) usr = 0;
            cyc();
        end
        chk("fail_exit", st, 1);
        chk("fail_clr", fail, 0);
        usr = 0; calib = 1;
        wait_state(3'd4, 60, "boot2_run");
        repeat (12) cyc();

        // debounce: short pulse ignored, long pulse = one soft reset
        usr = 1;
        repeat (5) cyc();
        usr = 0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (st != 3'd4) cnt++;
        end
        chk("deb_short", cnt, 0);
        nb = boot ^ 2'($urandom_range(1, 3));
        bmode = nb;
        usr = 1; n3 = 0; ent = 0; dhi = 0; prev = st;
        for (int i = 0; i < 45; i++) begin
            if (i == 20) usr = 0;
            cyc();
            if (st == 3'd3) n3++;
            if (st == 3'd3 && prev != 3'd3) ent++;
            if (dram_rst) dhi++;
            prev = st;
        end
        chk("deb_soc_len", n3, HOLD);
        chk("deb_soc_ent", ent, 1);
        chk("deb_dram", dhi, 0);
        chk("deb_boot", boot, nb);
        chk("deb_run", st, 4);

        // lock loss in RUN for 3 cycles
        lock = 0;
        repeat (3) cyc();
        chk("ll_hold", st, 4);
        lock = 1;
        cyc();
        chk("ll_state", st, 0);
        chk("ll_rsts", {dram_rst, soc_rst_n, usb_rst_n}, 3'b100);
        k = 1; t_soc = -1; cnt1 = 0;
        while (k < 40 && t_soc < 0) begin
            cyc();
            k++;
            if (st == 3'd1) cnt1++;
            if (soc_rst_n) t_soc = k - 1;
        end
        chk("relock_lat", t_soc, 2 * HOLD + 4);
        chk("relock_drst", cnt1, HOLD);
        repeat (4) cyc();

        // calibration drop in RUN
        calib = 0;
        for (int i = 0; i < 10 && st == 3'd4; i++) cyc();
        chk("cd_state", st, 1);
        chk("cd_soc", {soc_rst_n, usb_rst_n}, 2'b00);
        calib = 1;
        wait_state(3'd4, 60, "cd_run");
        repeat (12) cyc();

        // calibration drop on the same cycle the user request is accepted
        usr = 1;
        repeat (DEB - 1) cyc();
        calib = 0;
        for (int i = 0; i < 12 && st == 3'd4; i++) cyc();
        chk("cdu_state", st, 1);
        usr = 0; calib = 1;
        wait_state(3'd4, 60, "cdu_run");
        repeat (12) cyc();

        // async reset during WAIT_CALIB
        calib = 0;
        wait_state(3'd2, 20, "ar_wc");
        pulse_reset();
        calib = 1;
        wait_state(3'd4, 60, "ar_run");

        // random segments
        for (int s = 0; s < 120; s++) begin
            lock  = ($urandom_range(0, 7) != 0);
            calib = ($urandom_range(0, 3) != 0);
            usr   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) pulse_reset();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                bmode = 2'($urandom);
                cyc();
            end
        end

        chk("nodram_tied", dram0_hi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
